neuron_accumulator: RTL and testbench



---
 rtl/neuron_accumulator_pkg.sv | 26 ++
 rtl/neuron_accumulator_sat_clip.sv | 36 +++
 rtl/neuron_accumulator.sv | 115 +++++++++++
 tb/tb_neuron_accumulator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_accumulator_pkg.sv
// rtl/neuron_accumulator_pkg.sv - shared types and width/saturation helpers for the neuron accumulator
package neuron_accumulator_pkg;

    // Input-side phase of the current result: waiting for a first beat, or mid-result
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    // Accumulator width: enough headroom for bias plus BEATS partial sums, plus a sign guard bit,
    // so the running sum can never wrap before saturation is applied
    function automatic int acc_width(input int width, input int beats);
        return width + $clog2(beats + 1) + 1;
    endfunction

    // Most positive signed value representable in w bits
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative signed value representable in w bits
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/neuron_accumulator_sat_clip.sv
// rtl/neuron_accumulator_sat_clip.sv - combinational signed clip from IN_W bits down to OUT_W bits
module sat_clip
    import neuron_accumulator_pkg::*;
#(
    parameter int IN_W  = 36,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  value_i,
    output logic signed [OUT_W-1:0] clip_o,
    output logic                    ovf_o
);

    // Range limits expressed at the input width for comparison, and at the output width for the result
    localparam logic signed [IN_W-1:0]  MAX_IN  = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0]  MIN_IN  = IN_W'(sat_min(OUT_W));
    localparam logic signed [OUT_W-1:0] MAX_OUT = OUT_W'(sat_max(OUT_W));
    localparam logic signed [OUT_W-1:0] MIN_OUT = OUT_W'(sat_min(OUT_W));

    logic above;
    logic below;

    // Compare against the representable range and select either a rail or the truncated value
    always_comb begin
        above = (value_i > MAX_IN);
        below = (value_i < MIN_IN);
        if (above) begin
            clip_o = MAX_OUT;
        end else if (below) begin
            clip_o = MIN_OUT;
        end else begin
            clip_o = value_i[OUT_W-1:0];
        end
        ovf_o = above | below;
    end

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - multi-beat partial-sum accumulator with bias, saturation and valid/ready output
module neuron_accumulator
    import neuron_accumulator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] i,
    input  logic signed [WIDTH-1:0] i_bias,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic signed [WIDTH-1:0] o,
    output logic                    o_ovf,
    output logic                    o_valid,
    input  logic                    o_ready
);

    localparam int AW = acc_width(WIDTH, BEATS);
    // A one-beat configuration still gets a 1-bit counter; it simply never leaves zero
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    acc_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [WIDTH-1:0] o_q, o_d;
    logic                    o_ovf_q, o_ovf_d;
    logic                    o_valid_q, o_valid_d;

    logic                    beat_fire;
    logic                    last_beat;
    logic signed [AW-1:0]    i_ext;
    logic signed [AW-1:0]    bias_ext;
    logic signed [AW-1:0]    acc_base;
    logic signed [AW-1:0]    acc_next;
    logic signed [WIDTH-1:0] sat_value;
    logic                    sat_ovf;

    // Upstream may push whenever the output slot is empty or is being drained this cycle
    assign i_ready = !o_valid_q || o_ready;

    // Sum for the beat being presented: a fresh result starts from the bias, otherwise from the running sum
    always_comb begin
        beat_fire = i_valid && i_ready;
        last_beat = (cnt_q == LAST_CNT);
        i_ext     = {{(AW - WIDTH){i[WIDTH-1]}}, i};
        bias_ext  = {{(AW - WIDTH){i_bias[WIDTH-1]}}, i_bias};
        acc_base  = (state_q == ST_IDLE) ? bias_ext : acc_q;
        acc_next  = acc_base + i_ext;
    end

    sat_clip #(
        .IN_W  (AW),
        .OUT_W (WIDTH)
    ) u_sat_clip (
        .value_i (acc_next),
        .clip_o  (sat_value),
        .ovf_o   (sat_ovf)
    );

    // Next-state: drain the output slot, then either close the result or fold the beat into the sum
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        o_d       = o_q;
        o_ovf_d   = o_ovf_q;
        o_valid_d = o_valid_q;

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (beat_fire) begin
            if (last_beat) begin
                // A closing beat loads the slot even when the previous result leaves this same cycle
                o_d       = sat_value;
                o_ovf_d   = sat_ovf;
                o_valid_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end else begin
                acc_d     = acc_next;
                cnt_d     = cnt_q + CW'(1);
                state_d   = ST_ACC;
            end
        end
    end

    // State registers; reset drops any partial sum and empties the output slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            o_q       <= '0;
            o_ovf_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            o_q       <= o_d;
            o_ovf_q   <= o_ovf_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o       = o_q;
    assign o_ovf   = o_ovf_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - randomized scoreboard bench for neuron_accumulator (BEATS=4 and BEATS=1)
module tb_neuron_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic signed [15:0] i4, i4_bias, o4;
    logic               i4_valid, i4_ready, o4_ovf, o4_valid, o4_ready;
    logic signed [15:0] i1, i1_bias, o1;
    logic               i1_valid, i1_ready, o1_ovf, o1_valid, o1_ready;

    int n_checks = 0;
    int n_errors = 0;

    longint exp_o4[$];
    bit     exp_f4[$];
    int     out_cyc4[$];
    longint exp_o1[$];
    bit     exp_f1[$];
    int     out_cyc1[$];
    int     pres_cyc4, pres_cyc1;
    bit     done4, done1;

    neuron_accumulator #(.WIDTH(16), .BEATS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i(i4), .i_bias(i4_bias), .i_valid(i4_valid), .i_ready(i4_ready),
        .o(o4), .o_ovf(o4_ovf), .o_valid(o4_valid), .o_ready(o4_ready)
    );

    neuron_accumulator #(.WIDTH(16), .BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i(i1), .i_bias(i1_bias), .i_valid(i1_valid), .i_ready(i1_ready),
        .o(o1), .o_ovf(o1_ovf), .o_valid(o1_valid), .o_ready(o1_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, then clip into the signed 16-bit range
    function automatic longint clip16(input longint s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic bit ovf16(input longint s);
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic int rand16();
        logic signed [15:0] r;
        case ($urandom_range(0, 5))
            0:       r = 16'sh7fff;
            1:       r = 16'sh8000;
            default: r = 16'($urandom);
        endcase
        return int'(r);
    endfunction

    // Scoreboard: every handshake on either output must match the next predicted result
    always @(negedge clk) begin
        if (rst_n && o4_valid && o4_ready) begin
            out_cyc4.push_back(cyc);
            if (exp_o4.size() == 0) check("o4_unexpected", 1, 0);
            else begin
                check("o4_value", o4, exp_o4.pop_front());
                check("o4_ovf", o4_ovf, exp_f4.pop_front());
            end
        end
        if (rst_n && o1_valid && o1_ready) begin
            out_cyc1.push_back(cyc);
            if (exp_o1.size() == 0) check("o1_unexpected", 1, 0);
            else begin
                check("o1_value", o1, exp_o1.pop_front());
                check("o1_ovf", o1_ovf, exp_f1.pop_front());
            end
        end
    end

    task automatic beat4(input int bias, input int x);
        bit ok;
        ok = 0;
        i4_bias = 16'(bias); i4 = 16'(x); i4_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (i4_ready) begin ok = 1; pres_cyc4 = cyc; break; end
        end
        if (!ok) check("beat4_stuck", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic beat1(input int bias, input int x);
        bit ok;
        ok = 0;
        i1_bias = 16'(bias); i1 = 16'(x); i1_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (i1_ready) begin ok = 1; pres_cyc1 = cyc; break; end
        end
        if (!ok) check("beat1_stuck", 0, 1);
        @(posedge clk); #1;
    endtask

    // One full neuron; later beats carry a junk bias, which must be ignored
    task automatic neuron4(input int bias, input int b0, input int b1, input int b2, input int b3,
                           input bit gap, input bit keep);
        int     b[4];
        longint s;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        s = longint'(bias) + b0 + b1 + b2 + b3;
        exp_o4.push_back(clip16(s));
        exp_f4.push_back(ovf16(s));
        for (int k = 0; k < 4; k++) begin
            if (gap && $urandom_range(0, 2) == 0) begin
                i4_valid = 1'b0;
                i4 = 16'($urandom);
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            beat4((k == 0) ? bias : int'($urandom), b[k]);
        end
        if (!keep) i4_valid = 1'b0;
    endtask

    task automatic neuron1(input int bias, input int x, input bit keep);
        longint s;
        s = longint'(bias) + x;
        exp_o1.push_back(clip16(s));
        exp_f1.push_back(ovf16(s));
        beat1(bias, x);
        if (!keep) i1_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        i4 = '0; i4_bias = '0; i4_valid = 1'b0; o4_ready = 1'b1;
        i1 = '0; i1_bias = '0; i1_valid = 1'b0; o1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_o4_valid", o4_valid, 0);
        check("rst_o4", o4, 0);
        check("rst_o4_ovf", o4_ovf, 0);
        check("rst_i4_ready", i4_ready, 1);
        check("rst_o1_valid", o1_valid, 0);
        @(posedge clk); #1;

        // Basic result, latency and single pulse
        n0 = out_cyc4.size();
        neuron4(10, 1, 2, 3, 4, 0, 0);
        repeat (4) @(negedge clk);
        check("basic_pulses", out_cyc4.size() - n0, 1);
        if (out_cyc4.size() > n0) check("basic_latency", out_cyc4[n0], pres_cyc4 + 1);
        @(posedge clk); #1;

        // Saturation at both rails
        neuron4(32000, 1000, 1000, 1000, 1000, 0, 0);
        neuron4(-32000, -1000, -1000, -1000, -1000, 0, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Backpressure: result held, input blocked, then drained while the next neuron starts
        o4_ready = 1'b0;
        neuron4(1, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        check("hold_valid", o4_valid, 1);
        check("hold_i_ready", i4_ready, 0);
        i4_valid = 1'b1; i4 = 16'sd999; i4_bias = 16'sd777;
        repeat (3) begin
            @(negedge clk);
            check("hold_blocked", i4_ready, 0);
            check("hold_o", o4, 5);
        end
        @(posedge clk); #1;
        i4_valid = 1'b0;
        o4_ready = 1'b1;
        neuron4(2, 3, 3, 3, 3, 0, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Continuous stream of three neurons: bias applied once each, results four cycles apart
        n0 = out_cyc4.size();
        neuron4(0, 1, 1, 1, 1, 0, 1);
        neuron4(100, 1, 1, 1, 1, 0, 1);
        neuron4(-100, 1, 1, 1, 1, 0, 0);
        repeat (4) @(negedge clk);
        check("stream_count", out_cyc4.size() - n0, 3);
        if (out_cyc4.size() >= n0 + 3) begin
            check("stream_gap1", out_cyc4[n0 + 1] - out_cyc4[n0], 4);
            check("stream_gap2", out_cyc4[n0 + 2] - out_cyc4[n0 + 1], 4);
        end
        @(posedge clk); #1;

        // Reset mid-accumulation discards the partial beats
        beat4(50, 7);
        beat4(11, 9);
        i4_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_o4_valid", o4_valid, 0);
        check("rst2_i4_ready", i4_ready, 1);
        @(posedge clk); #1;
        neuron4(0, 5, 5, 5, 5, 0, 0);
        repeat (3) begin @(posedge clk); #1; end

        // BEATS=1: latency, held result reloaded in the cycle it is consumed, back-to-back throughput
        o1_ready = 1'b0;
        neuron1(-3, 7, 0);
        @(negedge clk);
        check("b1_valid", o1_valid, 1);
        check("b1_o", o1, 4);
        @(posedge clk); #1;
        exp_o1.push_back(11); exp_f1.push_back(0);
        i1_valid = 1'b1; i1_bias = 16'sd5; i1 = 16'sd6;
        repeat (2) begin
            @(negedge clk);
            check("b1_blocked", i1_ready, 0);
            check("b1_hold", o1, 4);
        end
        @(posedge clk); #1;
        o1_ready = 1'b1;
        beat1(5, 6);
        i1_valid = 1'b0;
        @(negedge clk);
        check("b1_reload_valid", o1_valid, 1);
        check("b1_reload_o", o1, 11);
        @(posedge clk); #1;
        n0 = out_cyc1.size();
        for (int k = 0; k < 5; k++) neuron1(k * 3, -k, 1);
        i1_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b1_stream_count", out_cyc1.size() - n0, 5);
        for (int k = 1; k < 5; k++)
            if (out_cyc1.size() > n0 + k) check("b1_stream_gap", out_cyc1[n0 + k] - out_cyc1[n0 + k - 1], 1);
        @(posedge clk); #1;

        // Randomized traffic with random gaps and random downstream stalls on both instances
        done4 = 0; done1 = 0;
        fork
            begin
                for (int n = 0; n < 40; n++)
                    neuron4(rand16(), rand16(), rand16(), rand16(), rand16(), 1, 0);
                done4 = 1;
            end
            begin
                while (!done4) begin @(posedge clk); #1; o4_ready = ($urandom_range(0, 3) != 0); end
                o4_ready = 1'b1;
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    neuron1(rand16(), rand16(), $urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 3) == 0) begin
                        i1_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                i1_valid = 1'b0;
                done1 = 1;
            end
            begin
                while (!done1) begin @(posedge clk); #1; o1_ready = ($urandom_range(0, 2) != 0); end
                o1_ready = 1'b1;
            end
        join

        for (int k = 0; k < 200; k++) begin
            if (exp_o4.size() == 0 && exp_o1.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("left4", exp_o4.size(), 0);
        check("left1", exp_o1.size(), 0);
        check("idle_o4_valid", o4_valid, 0);
        check("idle_o1_valid", o1_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
